// File: rtl/frame_swap_if.sv
// frame_swap_if: pixel writer, scan-out and status signals of frame_swap_buffer.
// master = core/video-timing side, slave = the frame store.
interface frame_swap_if #(
    parameter int XW    = 8,
    parameter int YW    = 8,
    parameter int PIX_W = 8
);
    logic             wr_en;
    logic [XW-1:0]    wr_x;
    logic [YW-1:0]    wr_y;
    logic [PIX_W-1:0] wr_pix;
    logic             frame;
    logic             ce_pix;
    logic             de;
    logic             vblank;
    logic [8:0]       rd_x;
    logic [8:0]       rd_y;
    logic [PIX_W-1:0] pix_out;
    logic             pix_valid;
    logic             front_sel;
    logic             swap_pending;
    logic             clear_busy;
    logic [15:0]      drop_cnt;
    logic [7:0]       overrun_cnt;

    modport master (
        output wr_en, wr_x, wr_y, wr_pix, frame, ce_pix, de, vblank, rd_x, rd_y,
        input  pix_out, pix_valid, front_sel, swap_pending, clear_busy, drop_cnt, overrun_cnt
    );

    modport slave (
        input  wr_en, wr_x, wr_y, wr_pix, frame, ce_pix, de, vblank, rd_x, rd_y,
        output pix_out, pix_valid, front_sel, swap_pending, clear_busy, drop_cnt, overrun_cnt
    );
endinterface

// File: rtl/frame_swap_buffer.sv
// frame_swap_buffer: ping-pong frame store. The core renders into the back
// bank while scan-out reads the front bank; banks swap only in vertical blank.
// Optional feature macro FB_CLEAR_EN: every swap starts a sweep that zeroes
// the new back bank, one word per clock; core writes are dropped meanwhile.
module frame_swap_buffer #(
    parameter int XW    = 8,
    parameter int YW    = 8,
    parameter int PIX_W = 8
) (
    input  logic        clk_sys,
    input  logic        reset,
    frame_swap_if.slave fb
);
    localparam int AW     = XW + YW;
    localparam int RD_LAT = 2;

    logic [PIX_W-1:0]  ram [2**(AW+1)];

    logic              front_sel;
    logic              swap_pending;
    logic              frame_d;
    logic              clear_busy;
    logic [15:0]       drop_cnt;
    logic [7:0]        overrun_cnt;

    logic              frame_edge;
    logic              swap_go;
    logic              wr_ok;

    logic              ram_we;
    logic [AW:0]       ram_wa;
    logic [PIX_W-1:0]  ram_wd;
    logic [AW:0]       rd_addr;
    logic [PIX_W-1:0]  ram_q;

    logic              de_q;
    logic              oor_q;
    logic [RD_LAT-1:0] vld_pipe;
    logic [PIX_W-1:0]  pix_out;

    // Scan bits above the bank size only matter through the out-of-range flag.
    logic              unused_rd_hi;
    assign unused_rd_hi = ^{fb.rd_x, fb.rd_y};

    assign frame_edge = fb.frame & ~frame_d;
    // A sweep in progress holds the swap off until the back bank is clean.
    assign swap_go    = swap_pending & fb.vblank & ~clear_busy;
    assign wr_ok      = fb.wr_en & ~swap_pending & ~clear_busy;
    // Reads always target the front bank, writes the back bank: no collisions.
    assign rd_addr    = {front_sel, fb.rd_y[YW-1:0], fb.rd_x[XW-1:0]};

    // Frame handshake: edge detect, pending request, bank flip, overrun count.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            frame_d      <= 1'b1;
            swap_pending <= 1'b0;
            front_sel    <= 1'b0;
            overrun_cnt  <= '0;
        end else begin
            frame_d <= fb.frame;
            if (swap_go) begin
                // A coincident edge becomes the next request, not an overrun.
                front_sel    <= ~front_sel;
                swap_pending <= frame_edge;
            end else if (frame_edge) begin
                if (!swap_pending)
                    swap_pending <= 1'b1;
                else if (overrun_cnt != 8'hFF)
                    overrun_cnt <= overrun_cnt + 8'd1;
            end
        end
    end

    // Saturating count of core writes refused while pending or sweeping.
    always_ff @(posedge clk_sys) begin
        if (reset)
            drop_cnt <= '0;
        else if (fb.wr_en && !wr_ok && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
    end

`ifdef FB_CLEAR_EN
    logic [AW-1:0] clr_addr;

    // Back-bank clear sweep: starts on the swap, visits every address once.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clear_busy <= 1'b0;
            clr_addr   <= '0;
        end else if (swap_go) begin
            clear_busy <= 1'b1;
            clr_addr   <= '0;
        end else if (clear_busy) begin
            clr_addr <= clr_addr + 1'b1;
            if (clr_addr == '1)
                clear_busy <= 1'b0;
        end
    end
`else
    assign clear_busy = 1'b0;
`endif

    // Single write port shared by the core and the clear sweep.
    always_comb begin
        ram_we = 1'b0;
        ram_wa = {~front_sel, fb.wr_y, fb.wr_x};
        ram_wd = fb.wr_pix;
        if (!reset) begin
`ifdef FB_CLEAR_EN
            if (clear_busy) begin
                ram_we = 1'b1;
                ram_wa = {~front_sel, clr_addr};
                ram_wd = '0;
            end
`endif
            if (wr_ok)
                ram_we = 1'b1;
        end
    end

    // Dual-port RAM with registered read; contents survive reset.
    always_ff @(posedge clk_sys) begin
        if (ram_we)
            ram[ram_wa] <= ram_wd;
        if (fb.ce_pix)
            ram_q <= ram[rd_addr];
    end

    // Read pipeline: strobe -> RAM word -> blanked pixel, one result per strobe.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            vld_pipe <= '0;
            de_q     <= 1'b0;
            oor_q    <= 1'b0;
            pix_out  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[RD_LAT-2:0], fb.ce_pix};
            if (fb.ce_pix) begin
                de_q  <= fb.de;
                oor_q <= fb.rd_x[8] | fb.rd_y[8];
            end
            if (vld_pipe[0])
                pix_out <= (de_q & ~oor_q) ? ram_q : '0;
        end
    end

    assign fb.pix_out      = pix_out;
    assign fb.pix_valid    = vld_pipe[RD_LAT-1];
    assign fb.front_sel    = front_sel;
    assign fb.swap_pending = swap_pending;
    assign fb.clear_busy   = clear_busy;
    assign fb.drop_cnt     = drop_cnt;
    assign fb.overrun_cnt  = overrun_cnt;
endmodule

// File: tb/tb_frame_swap_buffer.sv
// tb_frame_swap_buffer: directed scenarios plus random traffic, checked every
// cycle against a frame-level model (two bank arrays, a pending flag, counters).
module tb_frame_swap_buffer;
`ifdef FB_CLEAR_EN
    localparam int XW = 6;
    localparam int YW = 6;
`else
    localparam int XW = 8;
    localparam int YW = 8;
`endif
    localparam int PIX_W = 8;
    localparam int NA    = 1 << (XW + YW);

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_sys = ~clk_sys;

    frame_swap_if #(.XW(XW), .YW(YW), .PIX_W(PIX_W)) fb ();

    frame_swap_buffer #(.XW(XW), .YW(YW), .PIX_W(PIX_W)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .fb      (fb)
    );

    typedef struct { int due; logic [7:0] val; bit chk; } rd_t;

    logic [7:0] mem   [2][NA];
    bit         known [2][NA];
    bit         m_front, m_pend, m_frame_d;
    int         m_drop, m_ovr, m_clr;
    rd_t        rq[$];
    int         cyc, pv_count;
    int         n_chk, n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int addr_of(input int x, input int y);
        return (y % (1 << YW)) * (1 << XW) + (x % (1 << XW));
    endfunction

    // One clock: update the model from the current inputs, then compare.
    task automatic tick();
        bit  edge_ev, swap, was_rst, exp_v;
        int  a;
        rd_t r;
        edge_ev = fb.frame && !m_frame_d;
        swap    = m_pend && fb.vblank && (m_clr == 0);
        was_rst = reset;
        if (reset) begin
            if (m_clr > 0)
                for (int i = 0; i < NA; i++) known[!m_front][i] = 1'b0;
            m_front = 0; m_pend = 0; m_drop = 0; m_ovr = 0; m_clr = 0; m_frame_d = 1;
            rq.delete();
        end else begin
            if (fb.ce_pix) begin
                a = addr_of(int'(fb.rd_x), int'(fb.rd_y));
                if (fb.de && fb.rd_x < 256 && fb.rd_y < 256) begin
                    r.val = mem[m_front][a];
                    r.chk = known[m_front][a];
                end else begin
                    r.val = 8'h00;
                    r.chk = 1'b1;
                end
                r.due = cyc + 2;
                rq.push_back(r);
            end
            if (fb.wr_en) begin
                if (!m_pend && m_clr == 0) begin
                    a = addr_of(int'(fb.wr_x), int'(fb.wr_y));
                    mem[!m_front][a]   = fb.wr_pix;
                    known[!m_front][a] = 1'b1;
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
            end
            if (m_clr > 0) m_clr--;
            if (swap) begin
                m_front = !m_front;
                m_pend  = edge_ev;
`ifdef FB_CLEAR_EN
                m_clr = NA;
                for (int i = 0; i < NA; i++) begin
                    mem[!m_front][i]   = 8'h00;
                    known[!m_front][i] = 1'b1;
                end
`endif
            end else if (edge_ev) begin
                if (!m_pend) m_pend = 1;
                else if (m_ovr < 255) m_ovr++;
            end
            m_frame_d = fb.frame;
        end
        @(posedge clk_sys);
        #1;
        cyc++;
        if (fb.pix_valid) pv_count++;
        check("front_sel", fb.front_sel, m_front);
        check("swap_pending", fb.swap_pending, m_pend);
        check("drop_cnt", fb.drop_cnt, m_drop);
        check("overrun_cnt", fb.overrun_cnt, m_ovr);
        check("clear_busy", fb.clear_busy, m_clr > 0);
        exp_v = (rq.size() > 0) && (rq[0].due == cyc);
        check("pix_valid", fb.pix_valid, exp_v);
        if (exp_v) begin
            r = rq.pop_front();
            if (r.chk) check("pix_out", fb.pix_out, r.val);
        end
        if (was_rst) check("pix_out_rst", fb.pix_out, 0);
    endtask

    task automatic wait_clear();
        int n;
        n = 0;
        while (fb.clear_busy && n < NA + 8) begin
            tick();
            n++;
        end
        if (fb.clear_busy) check("clear_timeout", 1, 0);
    endtask

    task automatic swap_now();
        wait_clear();
        fb.frame = 1; tick();
        fb.frame = 0; fb.vblank = 1; tick();
        fb.vblank = 0;
    endtask

    task automatic wr(input int x, input int y, input logic [7:0] p);
        fb.wr_en = 1; fb.wr_x = XW'(x); fb.wr_y = YW'(y); fb.wr_pix = p;
        tick();
        fb.wr_en = 0;
    endtask

    task automatic rd_chk(input int x, input int y, input bit d, input logic [7:0] exp, input string tag);
        fb.ce_pix = 1; fb.de = d; fb.rd_x = 9'(x); fb.rd_y = 9'(y);
        tick();
        fb.ce_pix = 0;
        tick();
        check(tag, fb.pix_out, exp);
    endtask

    initial begin
        bit f0;
        int o0, d0, pv0, n;
        fb.wr_en = 0; fb.wr_x = '0; fb.wr_y = '0; fb.wr_pix = '0; fb.frame = 0;
        fb.ce_pix = 0; fb.de = 0; fb.vblank = 0; fb.rd_x = '0; fb.rd_y = '0;
        m_frame_d = 1; cyc = 0; pv_count = 0; n_chk = 0; n_fail = 0;

        reset = 1; repeat (3) tick(); reset = 0;
        check("rst_front", fb.front_sel, 0);

        // Write into bank 1, swap in vblank, read back with 2-cycle latency.
        wr(5, 3, 8'hE0);
        fb.frame = 1; tick(); fb.frame = 0; tick();
        check("tp1_pending", fb.swap_pending, 1);
        fb.vblank = 1; tick(); fb.vblank = 0;
        check("tp1_front", fb.front_sel, 1);
        fb.ce_pix = 1; fb.de = 1; fb.rd_x = 9'd5; fb.rd_y = 9'd3; tick(); fb.ce_pix = 0;
        check("tp1_lat1", fb.pix_valid, 0);
        tick();
        check("tp1_valid", fb.pix_valid, 1);
        check("tp1_pix", fb.pix_out, 8'hE0);

        // Writes while a swap is pending are dropped and leave the RAM alone.
        fb.frame = 1; tick(); fb.frame = 0;
        for (int i = 0; i < 10; i++) wr(5, 3, 8'h11);
        check("tp2_drop", fb.drop_cnt, 10);
        wait_clear();
        fb.vblank = 1; tick(); fb.vblank = 0;
        check("tp2_front", fb.front_sel, 0);
        wait_clear();
        wr(7, 7, 8'h5A);
        check("tp2_drop_after", fb.drop_cnt, 10);
        swap_now();
        rd_chk(7, 7, 1, 8'h5A, "tp2_new");
`ifdef FB_CLEAR_EN
        rd_chk(5, 3, 1, 8'h00, "tp2_cleared");
`else
        rd_chk(5, 3, 1, 8'hE0, "tp2_kept");
`endif

        // Three edges before vblank: two overruns, a single swap.
        wait_clear();
        f0 = m_front;
        repeat (3) begin fb.frame = 1; tick(); fb.frame = 0; tick(); end
        check("tp3_ovr", fb.overrun_cnt, 2);
        fb.vblank = 1; repeat (3) tick(); fb.vblank = 0;
        check("tp3_front", fb.front_sel, !f0);
        check("tp3_pending", fb.swap_pending, 0);

        // Blanked and out-of-range reads, then 1000 back-to-back strobes.
        wait_clear();
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) wr(x, y, 8'(x * 16 + y + 1));
        swap_now();
        rd_chk(256, 0, 1, 8'h00, "tp4_oor_x");
        rd_chk(3, 300, 1, 8'h00, "tp4_oor_y");
        rd_chk(2, 2, 0, 8'h00, "tp4_de0");
        rd_chk(2, 2, 1, 8'h23, "tp4_pat");
        pv0 = pv_count;
        fb.ce_pix = 1; fb.de = 1;
        for (int i = 0; i < 1000; i++) begin
            fb.rd_x = 9'($urandom_range(0, 15)); fb.rd_y = 9'($urandom_range(0, 15));
            tick();
        end
        fb.ce_pix = 0; tick(); tick();
        check("tp4_pulses", pv_count - pv0, 1000);

        // Frame edge in the swap cycle, then reset while pending and in flight.
        wait_clear();
        fb.frame = 1; tick(); fb.frame = 0; tick();
        f0 = m_front; o0 = m_ovr;
        fb.frame = 1; fb.vblank = 1; tick(); fb.frame = 0; fb.vblank = 0;
        check("tp5_front", fb.front_sel, !f0);
        check("tp5_pending", fb.swap_pending, 1);
        check("tp5_ovr", fb.overrun_cnt, o0);
        fb.ce_pix = 1; fb.de = 1; tick();
        reset = 1; fb.ce_pix = 0; tick(); reset = 0;
        check("tp5_rst_pend", fb.swap_pending, 0);
        check("tp5_rst_valid", fb.pix_valid, 0);
        check("tp5_rst_drop", fb.drop_cnt, 0);
        tick();

`ifdef FB_CLEAR_EN
        // Sweep length and write dropping during the sweep.
        fb.frame = 1; tick(); fb.frame = 0; fb.vblank = 1; tick(); fb.vblank = 0;
        d0 = m_drop; n = 0;
        while (fb.clear_busy && n < NA + 8) begin
            fb.wr_en = 1; fb.wr_x = XW'(n); fb.wr_y = '0; fb.wr_pix = 8'hFF;
            tick(); n++;
        end
        fb.wr_en = 0;
        check("clr_len", n, NA);
        check("clr_drop", fb.drop_cnt, d0 + NA);
        swap_now();
        rd_chk(40, 50, 1, 8'h00, "clr_read0");
`else
        d0 = 0; n = 0;
`endif

        // Random traffic against the model.
        for (int i = 0; i < 20000; i++) begin
            fb.wr_en  = $urandom_range(0, 1) == 1;
            fb.wr_x   = XW'($urandom_range(0, 15));
            fb.wr_y   = YW'($urandom_range(0, 15));
            fb.wr_pix = 8'($urandom);
            if ($urandom_range(0, 150) == 0) fb.frame = ~fb.frame;
            fb.vblank = (i % 400) < 30;
            fb.ce_pix = $urandom_range(0, 2) != 0;
            fb.de     = $urandom_range(0, 4) != 0;
            fb.rd_x   = ($urandom_range(0, 9) == 0) ? 9'(256 + $urandom_range(0, 255)) : 9'($urandom_range(0, 15));
            fb.rd_y   = ($urandom_range(0, 19) == 0) ? 9'(256 + $urandom_range(0, 255)) : 9'($urandom_range(0, 15));
            reset     = $urandom_range(0, 4999) == 0;
            tick();
        end
        reset = 0; fb.ce_pix = 0; fb.wr_en = 0;
        tick(); tick();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/frame_swap_buffer.md
Name: frame_swap_buffer

Overview:
- Double-buffered (ping-pong) pixel frame store between the core's pixel writer (hh/vv/red/green/blue/color_ready/frame) and the video-timing readout (hcount/vcount, CE_PIXEL, VGA_DE).
- The core renders into the back bank while the scan-out reads the front bank. Banks swap only during vertical blank, which removes tearing.
- Replaces the single shared vram array in emu. Output feeds VGA_R/G/B.

Parameters:
- XW, 8, write/read X address bits (bank width 2^XW)
- YW, 8, write/read Y address bits (bank height 2^YW)
- PIX_W, 8, pixel width; packing {r[2:0],g[2:0],b[1:0]}

Ports:
- clk_sys  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- wr_en  in  1  pixel write strobe (core color_ready)
- wr_x  in  XW  write column (hh)
- wr_y  in  YW  write row (vv)
- wr_pix  in  PIX_W  pixel value
- frame  in  1  core frame-done level; rising edge = back bank complete
- ce_pix  in  1  pixel clock enable
- de  in  1  display enable (~(HBlank|VBlank))
- vblank  in  1  vertical blank
- rd_x  in  9  scan column (hcount)
- rd_y  in  9  scan row (vcount)
- pix_out  out  PIX_W  scan-out pixel
- pix_valid  out  1  one-cycle pulse when pix_out updates
- front_sel  out  1  bank currently scanned out
- swap_pending  out  1  completed frame waiting for vblank
- clear_busy  out  1  back-bank clear sweep active (0 when feature off)
- drop_cnt  out  16  saturating count of rejected writes
- overrun_cnt  out  8  saturating count of frame edges seen while already pending

Behaviour:
- Reset values: front_sel=0, swap_pending=0, clear_busy=0, drop_cnt=0, overrun_cnt=0, pix_out=0, pix_valid=0, read pipeline valid bits=0. frame_d (edge register) resets to 1, so a frame level that is high at reset release is not treated as an edge. RAM contents are not cleared.
- Storage: simple dual-port RAM of 2·2^(XW+YW) words. Address = {bank, y, x}. Writes go to bank ~front_sel; reads come from bank front_sel. Reads and writes therefore never hit the same bank, and no collision logic is needed.
- Write acceptance: a write with wr_en=1 is committed that cycle only when swap_pending=0 and clear_busy=0. Otherwise the write is dropped and drop_cnt increments, saturating at 0xFFFF.
- Frame edge: frame & ~frame_d.
  - If swap_pending=0, set swap_pending.
  - If swap_pending=1, overrun_cnt increments (saturating at 0xFF) and the state is otherwise unchanged.
- Swap: on any cycle with swap_pending=1 && vblank=1, toggle front_sel and clear swap_pending, both registered.
  - If a frame edge and a swap qualify in the same cycle, the swap wins. The edge is then treated as a new pending request (swap_pending stays 1 with the new front_sel) and is not counted as an overrun.
- Read pipeline, fixed 2-cycle latency:
  - C0: ce_pix=1 captures {front_sel, rd_y, rd_x, de}, plus an out-of-range flag oor = rd_x[8] | rd_y[8].
  - C1: RAM registered read.
  - C2: pix_out <= (de_q & ~oor_q) ? ram_q : 0; pix_valid=1 for this single cycle.
  - pix_out holds its value between updates.
  - The bank used is the one captured at C0. A swap at C1 or C2 does not affect an in-flight read.
- ce_pix back-to-back on consecutive cycles is legal; the pipeline is fully pipelined with throughput of 1 per cycle.
- Reset asserted mid-operation: pending swap discarded, pipeline flushed (pix_valid=0 on the next cycle), any in-flight sweep aborted.

Optional Feature:
- FB_CLEAR_EN defined:
  - Each swap starts a sweep that writes 0 to every address of the new back bank, one address per clk_sys, from address 0 up to 2^(XW+YW)-1.
  - clear_busy=1 for exactly 2^(XW+YW) cycles, then 0.
  - Core writes during the sweep are dropped and counted in drop_cnt.
  - A new frame edge during the sweep still sets swap_pending normally.
  - A swap cannot occur while clear_busy=1; the swap waits for vblank after the sweep ends.
- FB_CLEAR_EN undefined: no sweep logic; clear_busy is tied to 0, and the back bank keeps the stale contents of the frame from two swaps earlier.

Test Plan:
- Reset; write 0xE0 at (x=5, y=3) into bank 1; pulse frame; raise vblank -> front_sel 0->1 on the following cycle. Then ce_pix + de with rd=(5,3) -> pix_out=0xE0 and pix_valid exactly 2 cycles after the strobe.
- Pulse frame with vblank=0; issue 10 wr_en -> swap_pending=1, drop_cnt=10, RAM unchanged. Raise vblank -> swap, then writes accepted again.
- Pulse frame 3 times before vblank -> overrun_cnt=2, one swap only.
- Read rd_x=256 or de=0 -> pix_out=0x00. 1000-cycle continuous ce_pix -> 1000 pix_valid pulses, in order.
- Frame edge coincident with the swap cycle -> front_sel toggles, swap_pending stays 1, overrun_cnt unchanged. Reset asserted during pending -> all outputs back to reset values next cycle.
- FB_CLEAR_EN: after a swap, clear_busy is high for 65536 cycles and wr_en in that window increments drop_cnt. After the next swap, reads of unwritten addresses return 0x00.
